// File: rtl/rom_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rom_ctrl_pkg
// Shared definitions for the AR/IMM/MEM microcode-ROM controllers:
//   en_t     ROM-select encoding driven on the en bus
//   state_t  sequencer state encoding
//   OP_W     width of the opcode field, which sits in the top OP_W bits of
//            every instruction word (instr[IW-1 -: OP_W])
// ----------------------------------------------------------------------------
package rom_ctrl_pkg;

    typedef enum logic [1:0] {
        EN_NONE = 2'b00,
        EN_AR   = 2'b01,
        EN_IMM  = 2'b10,
        EN_MEM  = 2'b11
    } en_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Opcode occupies the most significant OP_W bits of the instruction.
    localparam int OP_W = 4;

endpackage : rom_ctrl_pkg

// File: rtl/rom_class_dec.sv
// ----------------------------------------------------------------------------
// rom_class_dec
// Purely combinational opcode classifier shared by the ROM controllers.
//   op_i       [OP_W-1:0]  opcode field of the instruction
//   cls_o      en_t        ROM class (EN_NONE when illegal)
//   illegal_o  1           opcode belongs to no class
// Classes: 0000 -> AR; 1xxx -> MEM; 0xx0 with a set middle bit -> IMM;
// 0xx1 -> illegal. Every opcode falls into exactly one class.
// ----------------------------------------------------------------------------
module rom_class_dec
    import rom_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output en_t             cls_o,
    output logic            illegal_o
);

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cls_o     = EN_NONE;
        illegal_o = 1'b0;
        if (op_i[3]) begin
            cls_o = EN_MEM;
        end else if (op_i[0]) begin
            illegal_o = 1'b1;
        end else if (op_i[2] | op_i[1]) begin
            cls_o = EN_IMM;
        end else begin
            cls_o = EN_AR;
        end
    end

endmodule : rom_class_dec

// File: rtl/rom_seq_ctrl.sv
// ----------------------------------------------------------------------------
// rom_seq_ctrl
// Registered ROM-select sequencer. Accepts instructions on a valid/ready
// handshake, classifies them, and walks the selected microcode ROM through
// a per-class number of micro-steps, with a stall input that freezes the
// current step.
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   instr_valid  in   instruction offered
//   instr        in   [IW-1:0] instruction
//   instr_ready  out  controller can accept this cycle
//   stall        in   hold the current micro-step
//   en           out  [1:0] ROM select (00 none, 01 AR, 10 IMM, 11 MEM)
//   upc          out  [UW-1:0] micro-step address
//   instr_q      out  [IW-1:0] latched instruction for the ROMs
//   uop_valid    out  a micro-step is being presented
//   done         out  last micro-step retires this cycle
//   illegal      out  one-cycle pulse after an unclassifiable instruction
//   busy         out  sequencer is executing
// ----------------------------------------------------------------------------
module rom_seq_ctrl
    import rom_ctrl_pkg::*;
#(
    parameter int IW        = 8,
    parameter int UW        = 3,
    parameter int AR_STEPS  = 2,
    parameter int IMM_STEPS = 3,
    parameter int MEM_STEPS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    input  logic [IW-1:0] instr,
    output logic          instr_ready,
    input  logic          stall,
    output logic [1:0]    en,
    output logic [UW-1:0] upc,
    output logic [IW-1:0] instr_q,
    output logic          uop_valid,
    output logic          done,
    output logic          illegal,
    output logic          busy
);

    localparam logic [UW-1:0] AR_LAST  = UW'(AR_STEPS - 1);
    localparam logic [UW-1:0] IMM_LAST = UW'(IMM_STEPS - 1);
    localparam logic [UW-1:0] MEM_LAST = UW'(MEM_STEPS - 1);

    // Address of the final micro-step for a class.
    function automatic logic [UW-1:0] last_upc(input en_t cls);
        case (cls)
            EN_AR:   last_upc = AR_LAST;
            EN_IMM:  last_upc = IMM_LAST;
            EN_MEM:  last_upc = MEM_LAST;
            default: last_upc = '0;
        endcase
    endfunction

    state_t        state_q, state_d;
    en_t           en_q, en_d;
    logic [UW-1:0] upc_q, upc_d;
    logic [IW-1:0] instr_lat_q, instr_lat_d;
    logic          illegal_q, illegal_d;

    en_t           dec_cls;
    logic          dec_illegal;
    logic          last;
    logic          accept;

    // Classification looks at the incoming word; it only matters on the
    // cycle the instruction is accepted.
    rom_class_dec u_class_dec (
        .op_i      (instr[IW-1 -: OP_W]),
        .cls_o     (dec_cls),
        .illegal_o (dec_illegal)
    );

    assign last        = (state_q == EXEC) && (upc_q == last_upc(en_q));
    assign instr_ready = (state_q == IDLE) || (last && !stall);
    assign accept      = instr_valid && instr_ready;

    assign busy        = (state_q == EXEC);
    assign uop_valid   = busy;
    assign done        = last && !stall;

    assign en          = en_q;
    assign upc         = upc_q;
    assign instr_q     = instr_lat_q;
    assign illegal     = illegal_q;

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        upc_d       = upc_q;
        instr_lat_d = instr_lat_q;
        illegal_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_illegal) begin
                        illegal_d = 1'b1;
                    end else begin
                        state_d     = EXEC;
                        en_d        = dec_cls;
                        upc_d       = '0;
                        instr_lat_d = instr;
                    end
                end
            end

            EXEC: begin
                if (!stall) begin
                    if (!last) begin
                        upc_d = upc_q + UW'(1);
                    end else if (accept && !dec_illegal) begin
                        // Zero-bubble back-to-back issue: restart at step 0.
                        en_d        = dec_cls;
                        upc_d       = '0;
                        instr_lat_d = instr;
                    end else begin
                        state_d   = IDLE;
                        en_d      = EN_NONE;
                        upc_d     = '0;
                        illegal_d = accept;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                en_d    = EN_NONE;
                upc_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            en_q        <= EN_NONE;
            upc_q       <= '0;
            instr_lat_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            upc_q       <= upc_d;
            instr_lat_q <= instr_lat_d;
            illegal_q   <= illegal_d;
        end
    end

endmodule : rom_seq_ctrl

// File: tb/tb_rom_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rom_seq_ctrl
// Directed bench for rom_seq_ctrl with default parameters
// (IW=8, UW=3, AR=2, IMM=3, MEM=4 steps). Inputs change 1 ns after the
// rising edge; outputs are compared 2 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_rom_seq_ctrl;

    localparam int IW = 8;
    localparam int UW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          instr_valid = 1'b0;
    logic [IW-1:0] instr = '0;
    logic          stall = 1'b0;
    logic          instr_ready;
    logic [1:0]    en;
    logic [UW-1:0] upc;
    logic [IW-1:0] instr_q;
    logic          uop_valid;
    logic          done;
    logic          illegal;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    rom_seq_ctrl #(
        .IW        (IW),
        .UW        (UW),
        .AR_STEPS  (2),
        .IMM_STEPS (3),
        .MEM_STEPS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .stall       (stall),
        .en          (en),
        .upc         (upc),
        .instr_q     (instr_q),
        .uop_valid   (uop_valid),
        .done        (done),
        .illegal     (illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge (input drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".en"},        32'(en),          32'h0);
        check({tag, ".upc"},       32'(upc),         32'h0);
        check({tag, ".uop_valid"}, 32'(uop_valid),   32'h0);
        check({tag, ".busy"},      32'(busy),        32'h0);
        check({tag, ".done"},      32'(done),        32'h0);
        check({tag, ".ready"},     32'(instr_ready), 32'h1);
    endtask

    // One uop cycle: compare the presented step against expectations.
    task automatic check_uop(input string tag, input logic [1:0] e_en,
                             input logic [UW-1:0] e_upc, input logic e_done,
                             input logic e_ready, input logic [IW-1:0] e_iq);
        check({tag, ".en"},        32'(en),          32'(e_en));
        check({tag, ".upc"},       32'(upc),         32'(e_upc));
        check({tag, ".uop_valid"}, 32'(uop_valid),   32'h1);
        check({tag, ".busy"},      32'(busy),        32'h1);
        check({tag, ".done"},      32'(done),        32'(e_done));
        check({tag, ".ready"},     32'(instr_ready), 32'(e_ready));
        check({tag, ".instr_q"},   32'(instr_q),     32'(e_iq));
    endtask

    // Offer one instruction for a single cycle from IDLE, follow it through
    // n uop cycles, then confirm the return to IDLE.
    task automatic run_instr(input string tag, input logic [IW-1:0] ins,
                             input logic [1:0] e_en, input int n);
        cyc();
        instr_valid = 1'b1;
        instr       = ins;
        #1;
        check({tag, ".offer_ready"}, 32'(instr_ready), 32'h1);
        for (int i = 0; i < n; i++) begin
            cyc();
            instr_valid = 1'b0;
            instr       = '0;
            #1;
            check_uop($sformatf("%s.u%0d", tag, i), e_en, UW'(i), (i == n - 1),
                      (i == n - 1), ins);
        end
        cyc();
        #1;
        check_idle({tag, ".after"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #3;
        check_idle("reset");
        check("reset.instr_q", 32'(instr_q), 32'h0);
        check("reset.illegal", 32'(illegal), 32'h0);
        cyc();
        rst = 1'b1;
        cyc();

        // Single-cycle issue of each legal class.
        run_instr("ar",  8'h05, 2'b01, 2);
        run_instr("imm", 8'h20, 2'b10, 3);
        run_instr("mem", 8'h90, 2'b11, 4);
        run_instr("imm6", 8'h6E, 2'b10, 3);
        run_instr("memf", 8'hF1, 2'b11, 4);

        // Illegal opcode: single-cycle pulse, controller stays idle.
        cyc();
        instr_valid = 1'b1;
        instr       = 8'h10;
        #1;
        check("ill.offer_ready", 32'(instr_ready), 32'h1);
        cyc();
        instr_valid = 1'b0;
        instr       = '0;
        #1;
        check("ill.pulse", 32'(illegal), 32'h1);
        check_idle("ill.p");
        cyc();
        #1;
        check("ill.pulse_end", 32'(illegal), 32'h0);
        check_idle("ill.q");

        // MEM with a 3-cycle stall at step 2: 7 uop cycles in total.
        cyc();
        instr_valid = 1'b1;
        instr       = 8'h90;
        cyc();
        instr_valid = 1'b0;
        #1;
        check_uop("stl.u0", 2'b11, 3'd0, 1'b0, 1'b0, 8'h90);
        cyc();
        #1;
        check_uop("stl.u1", 2'b11, 3'd1, 1'b0, 1'b0, 8'h90);
        for (int i = 0; i < 3; i++) begin
            cyc();
            stall = 1'b1;
            #1;
            check_uop($sformatf("stl.s%0d", i), 2'b11, 3'd2, 1'b0, 1'b0, 8'h90);
        end
        cyc();
        stall = 1'b0;
        #1;
        check_uop("stl.u2", 2'b11, 3'd2, 1'b0, 1'b0, 8'h90);
        cyc();
        #1;
        check_uop("stl.u3", 2'b11, 3'd3, 1'b1, 1'b1, 8'h90);
        cyc();
        #1;
        check_idle("stl.after");

        // Stall on the last AR step gates done and ready.
        cyc();
        instr_valid = 1'b1;
        instr       = 8'h05;
        cyc();
        instr_valid = 1'b0;
        #1;
        check_uop("sl.u0", 2'b01, 3'd0, 1'b0, 1'b0, 8'h05);
        cyc();
        stall = 1'b1;
        #1;
        check_uop("sl.hold", 2'b01, 3'd1, 1'b0, 1'b0, 8'h05);
        cyc();
        stall = 1'b0;
        #1;
        check_uop("sl.u1", 2'b01, 3'd1, 1'b1, 1'b1, 8'h05);
        cyc();
        #1;
        check_idle("sl.after");

        // Back-to-back: AR 0x00 then IMM 0x40 held valid, no idle bubble.
        cyc();
        instr_valid = 1'b1;
        instr       = 8'h00;
        cyc();
        instr       = 8'h40;
        #1;
        check_uop("b2b.a0", 2'b01, 3'd0, 1'b0, 1'b0, 8'h00);
        cyc();
        #1;
        check_uop("b2b.a1", 2'b01, 3'd1, 1'b1, 1'b1, 8'h00);
        cyc();
        instr_valid = 1'b0;
        instr       = '0;
        #1;
        check_uop("b2b.i0", 2'b10, 3'd0, 1'b0, 1'b0, 8'h40);
        cyc();
        #1;
        check_uop("b2b.i1", 2'b10, 3'd1, 1'b0, 1'b0, 8'h40);
        cyc();
        #1;
        check_uop("b2b.i2", 2'b10, 3'd2, 1'b1, 1'b1, 8'h40);
        cyc();
        #1;
        check_idle("b2b.after");

        // Illegal offered in the last step: exit to IDLE with the pulse.
        cyc();
        instr_valid = 1'b1;
        instr       = 8'h05;
        cyc();
        instr       = 8'h30;
        cyc();
        #1;
        check("bi.done", 32'(done), 32'h1);
        cyc();
        instr_valid = 1'b0;
        instr       = '0;
        #1;
        check("bi.pulse", 32'(illegal), 32'h1);
        check_idle("bi.p");

        // Stall while idle has no effect on acceptance.
        cyc();
        stall       = 1'b1;
        instr_valid = 1'b1;
        instr       = 8'h20;
        #1;
        check("is.ready", 32'(instr_ready), 32'h1);
        cyc();
        stall       = 1'b0;
        instr_valid = 1'b0;
        #1;
        check_uop("is.u0", 2'b10, 3'd0, 1'b0, 1'b0, 8'h20);
        cyc();
        cyc();
        cyc();
        #1;
        check_idle("is.after");

        // Asynchronous reset at MEM step 1.
        cyc();
        instr_valid = 1'b1;
        instr       = 8'h90;
        cyc();
        instr_valid = 1'b0;
        cyc();
        #1;
        check_uop("rs.u1", 2'b11, 3'd1, 1'b0, 1'b0, 8'h90);
        #1;
        rst = 1'b0;
        #1;
        check_idle("rs.async");
        check("rs.instr_q", 32'(instr_q), 32'h0);
        cyc();
        rst = 1'b1;
        #1;
        check_idle("rs.release");
        cyc();
        #1;
        check_idle("rs.steady");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rom_seq_ctrl

// File: doc/rom_seq_ctrl.md
Name: rom_seq_ctrl

Overview:
Registered, parametrised successor to the combinational ROM-select decoder. Accepts instructions over a valid/ready handshake and classifies each one as AR (ALU/register file), IMM (immediate), MEM (memory) or illegal. For the selected ROM it holds the enable and drives a micro-step address through a per-class number of steps. Sits between instruction fetch and the AR/IMM/MEM microcode ROMs; supports back-to-back issue and a memory stall.

Parameters:
IW, 8, instruction width; the opcode is instr[IW-1:IW-4]; IW must be >= 4
UW, 3, micro-step address width
AR_STEPS, 2, micro-steps per AR instruction (1..2^UW)
IMM_STEPS, 3, micro-steps per IMM instruction (1..2^UW)
MEM_STEPS, 4, micro-steps per MEM instruction (1..2^UW)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
instr_valid  in  1  instruction offered
instr  in  IW  instruction
instr_ready  out  1  controller can accept this cycle
stall  in  1  hold the current micro-step (memory busy)
en  out  2  ROM select: 00 none, 01 AR, 10 IMM, 11 MEM
upc  out  UW  micro-step address to the selected ROM
instr_q  out  IW  latched instruction, forwarded to the ROMs
uop_valid  out  1  a micro-step is being presented
done  out  1  last micro-step retires this cycle
illegal  out  1  one-cycle pulse: the accepted instruction had no class
busy  out  1  state is EXEC

Behaviour:
- Reset (rst=0, async): state=IDLE, en=00, upc=0, instr_q=0, illegal=0. Combinational outputs follow from state: uop_valid=0, done=0, busy=0, instr_ready=1. A reset mid-instruction abandons it and issues no done.
- Decode, with op = instr[IW-1:IW-4]:
  - AR: op==0000.
  - IMM: op[3]=0, op[0]=0, (op[2]|op[1])=1.
  - MEM: op[3]=1.
  - Illegal: otherwise, i.e. op[3]=0, op[0]=1, op!=0001-with-zero-top… more precisely op[3]=0, op[0]=1.
- The class is decoded from the incoming instr at acceptance only; instr_q and en are registered at acceptance.
- Handshake: an instruction is accepted when instr_valid & instr_ready. instr_ready = IDLE | (EXEC & last & ~stall).
- States:
  - IDLE: en=00, uop_valid=0.
    - Accept legal -> EXEC; en=class, upc=0, instr_q=instr.
    - Accept illegal -> stay IDLE; illegal=1 for the next cycle only; en stays 00.
  - EXEC: uop_valid=1, busy=1. last = (upc == STEPS(en)-1).
    - stall=1: upc, en and instr_q hold; done=0; instr_ready=0.
    - stall=0 & ~last: upc+1.
    - stall=0 & last: done=1 (combinational, this cycle). Then:
      - A legal instruction accepted in the same cycle -> stay EXEC, upc=0, new en and instr_q (zero-bubble back-to-back).
      - An illegal one accepted -> IDLE with the illegal pulse.
      - Nothing accepted -> IDLE, en=00, upc=0.
- Latency: accept at edge N; first uop_valid in cycle N+1; done in cycle N+STEPS, plus stall cycles.
- STEPS=1: done in the first EXEC cycle.
- upc never exceeds STEPS-1 and never wraps.
- instr_valid while busy and not last: ignored, instr_ready=0. The source must hold the instruction.
- Stall while in IDLE has no effect.

Decomposition:
- Shared package rom_ctrl_pkg:
  - en encodings EN_NONE/EN_AR/EN_IMM/EN_MEM.
  - State encoding IDLE/EXEC.
  - Opcode field position constants.
- Sub-module rom_class_dec: combinational opcode -> {en class, illegal}. It is reused by any future ROM controller. The FSM and step counter stay in the top module.

Test Plan:
- Reset, then instr=0x05 (AR), valid for 1 cycle -> en=01; upc 0,1 in cycles N+1, N+2; done at N+2; then IDLE with en=00.
- instr=0x20 (IMM) -> en=10; upc 0,1,2; done on the third uop cycle. instr=0x90 (MEM) -> en=11, 4 uops.
- instr=0x10 (illegal) -> illegal=1 for exactly one cycle; en stays 00; uop_valid stays 0; instr_ready stays 1.
- MEM with stall=1 at upc=2 for 3 cycles -> upc holds at 2, done=0, instr_ready=0; then upc 3 and done; total 7 uop cycles.
- Back-to-back 0x00 then 0x40, the second held valid -> accepted in the AR last cycle; next cycle en=10, upc=0; no idle bubble.
- rst asserted at MEM upc=1 -> en=00, upc=0 immediately (asynchronous); no done. After release, instr_ready=1.
